// File: rtl/hdmi_tmds_pkg.sv
//------------------------------------------------------------------
// hdmi_tmds_pkg -- shared TMDS tokens, period encoding, latency. Rev 1.0
//------------------------------------------------------------------
`default_nettype none

package hdmi_tmds_pkg;

  localparam int LAT = 11;

  localparam logic [9:0] TOK_00  = 10'b1101010100;
  localparam logic [9:0] TOK_01  = 10'b0010101011;
  localparam logic [9:0] TOK_10  = 10'b0101010100;
  localparam logic [9:0] TOK_11  = 10'b1010101011;
  localparam logic [9:0] GB_CH02 = 10'b1011001100;
  localparam logic [9:0] GB_CH1  = 10'b0100110011;

  typedef enum logic [1:0] {
    PER_CTRL  = 2'd0,
    PER_PRE   = 2'd1,
    PER_GUARD = 2'd2,
    PER_VIDEO = 2'd3
  } period_e;

  // sync is {vsync, hsync}
  function automatic logic [9:0] ctrl_token(input logic [1:0] sync);
    logic [9:0] tok;
    case (sync)
      2'b00:   tok = TOK_00;
      2'b01:   tok = TOK_01;
      2'b10:   tok = TOK_10;
      default: tok = TOK_11;
    endcase
    return tok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tmds_delay_line.sv
//------------------------------------------------------------------
// tmds_delay_line -- WIDTH x DEPTH shift register, synchronous clear. Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module tmds_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign dout = r_stage[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/tmds_period_seq.sv
//------------------------------------------------------------------
// tmds_period_seq -- HDMI control/preamble/guard/video period sequencer. Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module tmds_period_seq
  import hdmi_tmds_pkg::*;
#(
  parameter int DVI_MODE = 0,
  parameter int SRST_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       de_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [9:0] ch0_in,
  input  logic [9:0] ch1_in,
  input  logic [9:0] ch2_in,
  output logic [9:0] ch0_out,
  output logic [9:0] ch1_out,
  output logic [9:0] ch2_out,
  output logic       serdes_rst,
  output logic [1:0] period,
  output logic       gap_err
);

  localparam int         DL_W     = 33;
  localparam int         DL_DEPTH = LAT - 1;
  localparam logic [3:0] LOW_SAT  = 4'd12;
  localparam logic [2:0] PRE_LAST = 3'd7;
  localparam int         SC_W     = (SRST_CYC < 1) ? 1 : $clog2(SRST_CYC + 1);
  localparam logic       TMDS_EN  = (DVI_MODE == 0);

  logic            r_srst;
  logic [SC_W-1:0] r_srst_cnt;
  logic [3:0]      r_low_cnt;
  logic            r_de_prev;
  period_e         r_state;
  period_e         w_state_nxt;
  logic [2:0]      r_pre_cnt;
  logic [2:0]      w_pre_cnt_nxt;
  logic            r_grd_cnt;
  logic            w_grd_cnt_nxt;

  logic [DL_W-1:0] w_dl_in;
  logic [DL_W-1:0] w_dl_out;
  logic            w_dl_clr;
  logic            w_de_d;
  logic [1:0]      w_sync_d;
  logic [9:0]      w_ch0_d;
  logic [9:0]      w_ch1_d;
  logic [9:0]      w_ch2_d;
  logic [9:0]      w_ch0_nxt;
  logic [9:0]      w_ch1_nxt;
  logic [9:0]      w_ch2_nxt;

  logic w_rise;
  logic w_active;
  logic w_qual;
  logic w_short;

  // Serializer reset stays high through rst plus SRST_CYC further cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_srst_cnt <= SC_W'(SRST_CYC);
      r_srst     <= 1'b1;
    end else begin
      r_srst <= (r_srst_cnt != '0);
      if (r_srst_cnt != '0) begin
        r_srst_cnt <= r_srst_cnt - SC_W'(1);
      end
    end
  end

  assign serdes_rst = r_srst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_low_cnt <= '0;
      r_de_prev <= 1'b0;
    end else begin
      r_de_prev <= de_in;
      if (de_in) begin
        r_low_cnt <= '0;
      end else if (r_low_cnt != LOW_SAT) begin
        r_low_cnt <= r_low_cnt + 4'd1;
      end
    end
  end

  // Rises are judged on the undelayed input so PRE can start 10 cycles before its video.
  assign w_rise   = de_in & ~r_de_prev;
  assign w_active = TMDS_EN & ~r_srst;
  assign w_qual   = w_rise & (r_low_cnt == LOW_SAT) & w_active;
  assign w_short  = w_rise & (r_low_cnt != LOW_SAT) & w_active;

  assign w_dl_in  = {de_in, vsync_in, hsync_in, ch2_in, ch1_in, ch0_in};
  assign w_dl_clr = rst | r_srst;

  tmds_delay_line #(
    .WIDTH (DL_W),
    .DEPTH (DL_DEPTH)
  ) u_delay (
    .clk  (clk),
    .clr  (w_dl_clr),
    .din  (w_dl_in),
    .dout (w_dl_out)
  );

  assign {w_de_d, w_sync_d, w_ch2_d, w_ch1_d, w_ch0_d} = w_dl_out;

  always_comb begin
    w_state_nxt   = r_state;
    w_pre_cnt_nxt = r_pre_cnt;
    w_grd_cnt_nxt = r_grd_cnt;
    case (r_state)
      PER_CTRL: begin
        if (w_qual) begin
          w_state_nxt   = PER_PRE;
          w_pre_cnt_nxt = 3'd0;
        end else if (w_de_d) begin
          w_state_nxt = PER_VIDEO;
        end
      end
      PER_PRE: begin
        if (r_pre_cnt == PRE_LAST) begin
          w_state_nxt   = PER_GUARD;
          w_grd_cnt_nxt = 1'b0;
        end else begin
          w_pre_cnt_nxt = r_pre_cnt + 3'd1;
        end
      end
      PER_GUARD: begin
        if (r_grd_cnt) begin
          w_state_nxt = PER_VIDEO;
        end else begin
          w_grd_cnt_nxt = 1'b1;
        end
      end
      PER_VIDEO: begin
        if (!w_de_d) begin
          w_state_nxt = PER_CTRL;
        end
      end
      default: w_state_nxt = PER_CTRL;
    endcase
    if (r_srst) begin
      w_state_nxt = PER_CTRL;
    end
  end

  // Output words follow the period the registers are about to enter.
  always_comb begin
    w_ch0_nxt = ctrl_token(w_sync_d);
    w_ch1_nxt = TOK_00;
    w_ch2_nxt = TOK_00;
    case (w_state_nxt)
      PER_PRE: w_ch1_nxt = TOK_01;
      PER_GUARD: begin
        w_ch0_nxt = GB_CH02;
        w_ch1_nxt = GB_CH1;
        w_ch2_nxt = GB_CH02;
      end
      PER_VIDEO: begin
        w_ch0_nxt = w_ch0_d;
        w_ch1_nxt = w_ch1_d;
        w_ch2_nxt = w_ch2_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= PER_CTRL;
      r_pre_cnt <= '0;
      r_grd_cnt <= 1'b0;
      ch0_out   <= TOK_00;
      ch1_out   <= TOK_00;
      ch2_out   <= TOK_00;
      gap_err   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pre_cnt <= w_pre_cnt_nxt;
      r_grd_cnt <= w_grd_cnt_nxt;
      ch0_out   <= w_ch0_nxt;
      ch1_out   <= w_ch1_nxt;
      ch2_out   <= w_ch2_nxt;
      if (w_short) begin
        gap_err <= 1'b1;
      end
    end
  end

  assign period = r_state;

endmodule

`default_nettype wire

// File: tb/tb_tmds_period_seq.sv
//------------------------------------------------------------------
// tb_tmds_period_seq -- directed bench, HDMI and DVI instances side by side. Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module tb_tmds_period_seq;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;
  localparam logic [9:0] G02 = 10'b1011001100;
  localparam logic [9:0] G1  = 10'b0100110011;

  logic       clk = 1'b0;
  logic       rst;
  logic       de_in, hsync_in, vsync_in;
  logic [9:0] ch0_in, ch1_in, ch2_in;

  logic [9:0] a_ch0, a_ch1, a_ch2, b_ch0, b_ch1, b_ch2;
  logic       a_srst, b_srst, a_gap, b_gap;
  logic [1:0] a_period, b_period;

  logic [9:0] lg0 [0:127];
  logic [9:0] lg1 [0:127];
  logic [9:0] lg2 [0:127];
  logic       lgv [0:127];
  logic       lgh [0:127];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tmds_period_seq #(.DVI_MODE(0), .SRST_CYC(4)) u_hdmi (
    .clk(clk), .rst(rst), .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .ch0_in(ch0_in), .ch1_in(ch1_in), .ch2_in(ch2_in),
    .ch0_out(a_ch0), .ch1_out(a_ch1), .ch2_out(a_ch2),
    .serdes_rst(a_srst), .period(a_period), .gap_err(a_gap)
  );

  tmds_period_seq #(.DVI_MODE(1), .SRST_CYC(4)) u_dvi (
    .clk(clk), .rst(rst), .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .ch0_in(ch0_in), .ch1_in(ch1_in), .ch2_in(ch2_in),
    .ch0_out(b_ch0), .ch1_out(b_ch1), .ch2_out(b_ch2),
    .serdes_rst(b_srst), .period(b_period), .gap_err(b_gap)
  );

  function automatic logic [9:0] tok(input logic [1:0] s);
    case (s)
      2'b00:   return T00;
      2'b01:   return T01;
      2'b10:   return T10;
      default: return T11;
    endcase
  endfunction

  task automatic chk(input string tag, input int c, input logic [9:0] obs, input logic [9:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, c, obs, exp);
    end
  endtask

  initial begin
    int         k;
    logic [1:0] es, ep0, ep1;
    logic [9:0] v0, v1, v2, e0, e1, e2;

    rst = 1'b1; de_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    ch0_in = '0; ch1_in = '0; ch2_in = '0;
    repeat (3) @(posedge clk);
    #1;

    // Loop body: check outputs of cycle c, then drive inputs sampled at the end of cycle c.
    for (int c = 0; c <= 110; c++) begin
      k  = c - 11;
      es = (k >= 0) ? {lgv[k], lgh[k]} : 2'b00;
      v0 = (k >= 0) ? lg0[k] : 10'h000;
      v1 = (k >= 0) ? lg1[k] : 10'h000;
      v2 = (k >= 0) ? lg2[k] : 10'h000;

      if (c inside {[21:28], [51:58], [91:98]})                 ep0 = 2'd1;
      else if (c inside {[29:30], [59:60], [99:100]})           ep0 = 2'd2;
      else if (c inside {[31:34], [41:42], [61:62], 101})       ep0 = 2'd3;
      else                                                      ep0 = 2'd0;
      ep1 = (c inside {[31:34], [41:42], [61:62], 101}) ? 2'd3 : 2'd0;

      case (ep0)
        2'd1:    begin e0 = tok(es); e1 = T01; e2 = T00; end
        2'd2:    begin e0 = G02;     e1 = G1;  e2 = G02; end
        2'd3:    begin e0 = v0;      e1 = v1;  e2 = v2;  end
        default: begin e0 = tok(es); e1 = T00; e2 = T00; end
      endcase
      chk("hdmi_period", c, {8'b0, a_period}, {8'b0, ep0});
      chk("hdmi_ch0", c, a_ch0, e0);
      chk("hdmi_ch1", c, a_ch1, e1);
      chk("hdmi_ch2", c, a_ch2, e2);
      chk("hdmi_gap_err", c, {9'b0, a_gap}, {9'b0, (c >= 31 && c <= 62)});
      chk("hdmi_serdes_rst", c, {9'b0, a_srst}, {9'b0, (c <= 4 || (c >= 63 && c <= 67))});

      if (ep1 == 2'd3) begin e0 = v0; e1 = v1; e2 = v2; end
      else begin e0 = tok(es); e1 = T00; e2 = T00; end
      chk("dvi_period", c, {8'b0, b_period}, {8'b0, ep1});
      chk("dvi_ch0", c, b_ch0, e0);
      chk("dvi_ch1", c, b_ch1, e1);
      chk("dvi_ch2", c, b_ch2, e2);
      chk("dvi_gap_err", c, {9'b0, b_gap}, 10'h000);
      chk("dvi_serdes_rst", c, {9'b0, b_srst}, {9'b0, (c <= 4 || (c >= 63 && c <= 67))});

      rst      = (c == 62);
      de_in    = (c inside {[20:23], [30:31], [50:53], 90});
      vsync_in = (c inside {[15:23]});
      hsync_in = (c inside {[40:45]});
      if (c inside {[20:23]}) begin
        ch0_in = 10'h155; ch1_in = 10'h2AA; ch2_in = 10'h0F0;
      end else if (c == 30) begin
        ch0_in = 10'h3FF; ch1_in = 10'h001; ch2_in = 10'h200;
      end else if (c == 31) begin
        ch0_in = 10'h0C3; ch1_in = 10'h30C; ch2_in = 10'h1E1;
      end else if (c == 51) begin
        ch0_in = 10'h044; ch1_in = 10'h088; ch2_in = 10'h0CC;
      end else if (c inside {50, 52, 53}) begin
        ch0_in = 10'h111; ch1_in = 10'h222; ch2_in = 10'h333;
      end else if (c == 90) begin
        ch0_in = 10'h0AA; ch1_in = 10'h155; ch2_in = 10'h3C0;
      end else begin
        ch0_in = 10'($urandom_range(1023));
        ch1_in = 10'($urandom_range(1023));
        ch2_in = 10'($urandom_range(1023));
      end
      lg0[c] = ch0_in; lg1[c] = ch1_in; lg2[c] = ch2_in;
      lgv[c] = vsync_in; lgh[c] = hsync_in;

      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
